// File: rtl/clk_div_int_pkg.sv
// Shared constants for the integer clock divider: bypass ratio thresholds
// and the encoding of the divided-clock phase register.
package clk_div_int_pkg;

    localparam int unsigned RATIO_BYPASS_ZERO = 32'd0;
    localparam int unsigned RATIO_BYPASS_ONE  = 32'd1;

    localparam logic PHASE_LOW  = 1'b0;
    localparam logic PHASE_HIGH = 1'b1;

endpackage

// File: rtl/clk_div_int.sv
// Integer clock divider producing the UART RX sampling clock from the
// reference clock; even/odd ratios, bypass for ratio 0/1 or when disabled.
module clk_div_int
    import clk_div_int_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Enable,
    input  logic [Width-1:0] Div_Ratio,
    output logic             Div_Clk
);

    logic [Width-1:0] cnt_r;
    logic [Width-1:0] ratio_q_r;
    logic             div_q_r;

    logic             active_s;
    logic             ratio_unloaded_s;
    logic [Width-1:0] eff_ratio_s;
    logic [Width-1:0] phase_len_s;
    logic             phase_end_s;

    // Active detection, effective ratio and phase-length compare.
    always_comb begin
        active_s = Enable
                   && (Div_Ratio != Width'(RATIO_BYPASS_ZERO))
                   && (Div_Ratio != Width'(RATIO_BYPASS_ONE));
        // After reset the latch holds 0; the live ratio stands in until loaded.
        ratio_unloaded_s = (ratio_q_r == Width'(RATIO_BYPASS_ZERO))
                           || (ratio_q_r == Width'(RATIO_BYPASS_ONE));
        if (ratio_unloaded_s) begin
            eff_ratio_s = Div_Ratio;
        end else begin
            eff_ratio_s = ratio_q_r;
        end
        if (div_q_r == PHASE_HIGH) begin
            phase_len_s = eff_ratio_s >> 1;
        end else begin
            phase_len_s = (eff_ratio_s >> 1) + {{(Width-1){1'b0}}, eff_ratio_s[0]};
        end
        phase_end_s = (cnt_r == (phase_len_s - Width'(1'b1)));
    end

    // Counter, divided-clock toggle and period-boundary ratio latch.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_r     <= {Width{1'b0}};
            div_q_r   <= PHASE_LOW;
            ratio_q_r <= {Width{1'b0}};
        end else if (!active_s) begin
            cnt_r     <= {Width{1'b0}};
            div_q_r   <= PHASE_LOW;
            ratio_q_r <= Div_Ratio;
        end else if (phase_end_s) begin
            cnt_r   <= {Width{1'b0}};
            div_q_r <= ~div_q_r;
            if ((div_q_r == PHASE_HIGH) || ratio_unloaded_s) begin
                ratio_q_r <= Div_Ratio;
            end else begin
                ratio_q_r <= ratio_q_r;
            end
        end else begin
            cnt_r <= cnt_r + Width'(1'b1);
            if (ratio_unloaded_s) begin
                ratio_q_r <= Div_Ratio;
            end else begin
                ratio_q_r <= ratio_q_r;
            end
        end
    end

    // Output select: registered divided clock, or the raw clock in bypass.
    always_comb begin
        if (active_s) begin
            Div_Clk = div_q_r;
        end else begin
            Div_Clk = CLK;
        end
    end

endmodule
